// File: rtl/mem_port_arbiter.sv
// Shares one single-port, fixed-latency memory between the fetch and data ports.
// Optional fetch starvation guard is built when ARB_STARVE_GUARD_EN is defined.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int WAIT_STATES  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

    localparam logic [3:0] LAST_CNT = 4'(WAIT_STATES - 1);

    if (WAIT_STATES < 1 || WAIT_STATES > 15) begin : g_bad_wait_states
        $error("mem_port_arbiter: WAIT_STATES must be 1..15");
    end
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
        $error("mem_port_arbiter: STARVE_LIMIT must be 1..15");
    end

    state_e              state_q,     state_d;
    owner_e              owner_q,     owner_d;
    logic [3:0]          wait_cnt_q,  wait_cnt_d;
    logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
    logic                mem_we_q,    mem_we_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0]   dm_rdata_q,  dm_rdata_d;

    logic arb_window;
    logic starve_force;
    logic grant_dm;
    logic grant_if;
    logic first_access;

    assign arb_window = (state_q == ST_IDLE) || (state_q == ST_RESP);

`ifdef ARB_STARVE_GUARD_EN
    logic [3:0] starve_cnt_q, starve_cnt_d;

    // Once fetch has lost STARVE_LIMIT arbitrations in a row it wins the next one.
    assign starve_force = if_req && (starve_cnt_q == 4'(STARVE_LIMIT));

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!if_req || grant_if) begin
            starve_cnt_d = '0;
        end else if (grant_dm) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    assign starve_force = 1'b0;
`endif

    // Data beats fetch: the load/store belongs to the older instruction.
    assign grant_dm = arb_window && dm_req && !starve_force;
    assign grant_if = arb_window && if_req && !grant_dm;

    always_comb begin
        // NOTE: every _d gets its hold value first, so no branch can infer a latch.
        state_d     = state_q;
        owner_d     = owner_q;
        wait_cnt_d  = wait_cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = mem_we_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;

        unique case (state_q)
            ST_IDLE, ST_RESP: begin
                wait_cnt_d = '0;
                if (grant_dm) begin
                    state_d     = ST_ACCESS;
                    owner_d     = OWN_DM;
                    mem_addr_d  = dm_addr;
                    mem_we_d    = dm_we;
                    mem_wdata_d = dm_wdata;
                end else if (grant_if) begin
                    state_d    = ST_ACCESS;
                    owner_d    = OWN_IF;
                    mem_addr_d = if_addr;
                    mem_we_d   = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_ACCESS: begin
                if (wait_cnt_q == LAST_CNT) begin
                    state_d    = ST_RESP;
                    wait_cnt_d = '0;
                    if (owner_q == OWN_IF) begin
                        if_rdata_d = mem_rdata;
                    end else if (!mem_we_q) begin
                        dm_rdata_d = mem_rdata;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: the data registers are reset too, so every output reads 0 in reset.
        if (!reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_IF;
            wait_cnt_q  <= '0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    assign first_access = (state_q == ST_ACCESS) && (wait_cnt_q == '0);

    assign mem_en    = first_access;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    assign if_gnt    = first_access && (owner_q == OWN_IF);
    assign dm_gnt    = first_access && (owner_q == OWN_DM);
    assign if_rvalid = (state_q == ST_RESP) && (owner_q == OWN_IF);
    assign dm_rvalid = (state_q == ST_RESP) && (owner_q == OWN_DM);
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;

    assign busy = (state_q != ST_IDLE);

endmodule
